// File: rtl/receive_pkg.sv
// receive_pkg: shared types and constants for the serial frame receiver.
// Holds the FSM state encoding, the data width, the default guard length
// and the widths of the bit-index and guard counters.
package receive_pkg;

   localparam int DATA_BITS      = 8;
   localparam int GUARD_BITS_DEF = 12;
   localparam int BIT_IDX_W      = $clog2(DATA_BITS);

   // Guard counter has to hold 0..GUARD_BITS inclusive.
   function automatic int guard_cnt_w(input int guard_bits);
      return $clog2(guard_bits + 1);
   endfunction

   localparam int GUARD_CNT_W = guard_cnt_w(GUARD_BITS_DEF);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_MARK  = 2'd2,
      ST_GUARD = 2'd3
   } rx_state_t;

endpackage

// File: rtl/receive_fifo.sv
// receive_fifo: small synchronous word FIFO for the frame receiver.
// Write and read in the same cycle while full both succeed. Reads while
// empty are ignored. The head word reads as zero while the FIFO is empty
// so the output is defined straight out of reset.
module receive_fifo
   import receive_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = DATA_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_rd_ok;
   logic             w_wr_ok;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign w_rd_ok   = i_rd && !o_empty;
   // A read on the same edge frees a slot, so a full FIFO can still accept.
   assign w_wr_ok   = i_wr && (!o_full || w_rd_ok);
   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage array; contents are only observed through valid pointers.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/receive.sv
// receive: serial frame receiver, one line bit per clock.
// Frame: start 0, 8 data bits LSB first, marker 0, GUARD_BITS idle ones.
// Finished words are queued in receive_fifo and leave over valid/ready.
// Build option: RECEIVE_FRAME_CHECK_EN enables marker and guard checking;
// without it the marker always writes, guard zeros are ignored and
// frame_error never rises.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | hunting for a start bit (rxd = 0)
// ST_DATA  | shifting in 8 data bits, LSB first
// ST_MARK  | sampling the marker bit; good word is pushed to the FIFO
// ST_GUARD | counting GUARD_BITS trailer cycles before hunting again
module receive
   import receive_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int GUARD_BITS = GUARD_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 connection_status,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] word,
   output logic                 word_valid,
   input  logic                 word_ready,
   output logic                 frame_error,
   output logic                 overflow
);

   localparam int GW = guard_cnt_w(GUARD_BITS);
   localparam logic [GW-1:0]        GUARD_LAST = GW'(GUARD_BITS - 1);
   localparam logic [GW-1:0]        GUARD_ONE  = GW'(1);
   localparam logic [BIT_IDX_W-1:0] BIT_LAST   = BIT_IDX_W'(DATA_BITS - 1);
   localparam logic [BIT_IDX_W-1:0] BIT_ONE    = BIT_IDX_W'(1);

`ifdef RECEIVE_FRAME_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   rx_state_t              r_state;
   logic [DATA_BITS-1:0]   r_shift;
   logic [BIT_IDX_W-1:0]   r_bit_idx;
   logic [GW-1:0]          r_guard_cnt;
   logic                   r_frame_error;
   logic                   r_overflow;

   logic                   w_mark_good;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic                   w_rd;
   logic                   w_drop;

   // A marker cycle produces a word unless the link is down or, with
   // checking on, the marker bit was sampled high.
   assign w_mark_good = connection_status && (r_state == ST_MARK) &&
                        (!rxd || !CHECK_EN);
   assign w_rd        = word_ready && !w_fifo_empty;
   assign w_drop      = w_mark_good && w_fifo_full && !w_rd;

   assign word_valid  = !w_fifo_empty;
   assign frame_error = r_frame_error;
   assign overflow    = r_overflow;

   receive_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_mark_good),
      .i_wr_data (r_shift),
      .i_rd      (word_ready),
      .o_rd_data (word),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   // Frame FSM with registered error/overflow pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_shift       <= '0;
         r_bit_idx     <= '0;
         r_guard_cnt   <= '0;
         r_frame_error <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_frame_error <= 1'b0;
         r_overflow    <= w_drop;
         if (!connection_status) begin
            // Link down: drop any partial frame, keep the FIFO intact.
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_guard_cnt <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (!rxd) begin
                     r_state   <= ST_DATA;
                     r_bit_idx <= '0;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {rxd, r_shift[DATA_BITS-1:1]};
                  r_bit_idx <= r_bit_idx + BIT_ONE;
                  if (r_bit_idx == BIT_LAST) begin
                     r_state <= ST_MARK;
                  end
               end
               ST_MARK: begin
                  if (w_mark_good) begin
                     r_state     <= ST_GUARD;
                     r_guard_cnt <= '0;
                  end else begin
                     r_frame_error <= 1'b1;
                     r_state       <= ST_IDLE;
                  end
               end
               ST_GUARD: begin
                  if (CHECK_EN && !rxd) begin
                     r_frame_error <= 1'b1;
                     r_state       <= ST_IDLE;
                  end else begin
                     r_guard_cnt <= r_guard_cnt + GUARD_ONE;
                     if (r_guard_cnt == GUARD_LAST) begin
                        r_state <= ST_IDLE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/receive.md
# receive

Serial frame receiver: the downstream partner of the serial transmitter in the same design. It samples the one-bit line at one bit per clock, finds start bits, and rebuilds 8-bit words LSB first. It checks the frame trailer and buffers finished words in a small FIFO. Words leave the FIFO over a valid/ready handshake.

## Interface
- DEPTH, 4, FIFO depth in words (power of two, ≥2)
- GUARD_BITS, 12, number of idle-high bits required after the marker bit
- clk  input  1  system clock; every line bit lasts exactly one cycle
- rst  input  1  asynchronous, active-high reset
- connection_status  input  1  link enable; low aborts any frame in progress
- rxd  input  1  serial line, idle high
- word  output  8  head-of-FIFO word
- word_valid  output  1  FIFO non-empty
- word_ready  input  1  consumer accepts `word` on a cycle where valid && ready
- frame_error  output  1  one-cycle pulse on a marker or guard violation
- overflow  output  1  one-cycle pulse when a good word is dropped because the FIFO is full

## Operation
- Line frame, as sampled on consecutive edges:
  - start bit 0
  - 8 data bits, LSB first
  - marker bit 0
  - GUARD_BITS ones
  - any further idle ones
- FSM states: IDLE, DATA, MARK, GUARD.
- IDLE: on sampling rxd=0 → DATA, bit index=0.
- DATA: shift rxd into the shift register at the MSB, shifting right. After the 8th data bit → MARK.
- MARK:
  - rxd=0: the word is good. Write it to the FIFO, or pulse overflow if the FIFO is full with no read this cycle. → GUARD, guard count=0.
  - rxd=1: pulse frame_error, no write, → IDLE.
- GUARD:
  - rxd=1: increment the guard count. At GUARD_BITS → IDLE.
  - rxd=0: pulse frame_error → IDLE. The word already written stays in the FIFO.
- connection_status low: FSM → IDLE, partial shift contents discarded. The FIFO is not flushed and reads continue.
- FIFO:
  - Read and write in the same cycle while full: both succeed and occupancy is unchanged.
  - Read while empty: ignored.
  - Pointers are log2(DEPTH) bits and wrap. Occupancy counter is log2(DEPTH)+1 bits.
- Reset values:
  - word=0, word_valid=0, frame_error=0, overflow=0
  - FSM=IDLE, FIFO empty, shift register=0

## Timing
- All state changes on the rising clk edge. rst acts immediately, independent of clk.
- Latency: the marker is sampled at edge N, word_valid=1 and the new word is visible after edge N. If the FIFO already held data, the new word is queued behind it.
- frame_error and overflow are registered and high for exactly the cycle after the offending edge.
- Minimum frame spacing: 1+8+1+GUARD_BITS cycles from start bit to next possible start detection.
- With the matching transmitter (14 idle-high cycles after the marker), back-to-back frames are received error-free at GUARD_BITS=12.
- rst asserted mid-frame: the frame is lost and the FIFO is cleared. After release, the receiver hunts for a new start bit.

## Configuration
- RECEIVE_FRAME_CHECK_EN defined: full marker and guard checking, as in Operation.
- Undefined:
  - MARK writes unconditionally.
  - GUARD and marker violations are ignored, and GUARD still counts cycles before returning to IDLE.
  - frame_error is tied to 0.

## Structure
- Package receive_pkg holds:
  - the FSM state enum
  - DATA_BITS=8
  - the default GUARD_BITS
  - the bit-index and guard-counter widths
- One sub-module, receive_fifo (parameter DEPTH): synchronous FIFO with write/read strobes, full/empty flags and async reset.

## Test plan
- Reset, then 0xA5 frame: rxd 0,1,0,1,0,0,1,0,1,0 then 12×1 → word=0xA5, word_valid high one cycle after the marker edge, frame_error=0.
- Marker sampled as 1 after data 0x3C → frame_error pulse, no write, word_valid stays 0. The next valid 0x11 frame is received normally.
- Five good frames 0x01..0x05 with word_ready=0 (DEPTH=4) → overflow pulse on the 5th. Draining yields 0x01..0x04 in order.
- FIFO full, word_ready=1 on the marker cycle of frame 0x77 → no overflow, and 0x77 appears after the existing entries.
- connection_status dropped after 4 data bits, then raised, then full frame 0xC3 → only 0xC3 delivered, no error.
- Guard broken by 0 at guard bit 5 (check enabled) → word delivered plus frame_error pulse. Rebuilt without RECEIVE_FRAME_CHECK_EN → same word, frame_error stays 0.
